// File: rtl/riscv_retire_monitor.sv
// rtl/riscv_retire_monitor.sv - retirement counter, result latch and halt-sequence detector
// Optional: define RETIRE_EBREAK_HALT_EN to make a retiring ebreak halt from any state.
module riscv_retire_monitor #(
    parameter logic [31:0] HALT_W0 = 32'h00c00093,
    parameter logic [31:0] HALT_W1 = 32'h00008067
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RET_VALID,
    input  logic [31:0] RET_INST,
    input  logic        RET_RF_WE,
    input  logic [31:0] RET_RF_WD,
    input  logic        RET_IS_BR,
    input  logic        RET_BR_TAKEN,
    input  logic        RET_IS_ST,
    input  logic [11:0] RET_ST_ADDR,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } state_t;

`ifdef RETIRE_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h00100073;
`endif

    state_t state_q;
    state_t state_d;
    logic   accept;

    // Once halted nothing further is accepted, so the checker sees a frozen snapshot.
    assign accept = RET_VALID && !HALT;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (RET_INST == HALT_W0)
                        state_d = ARMED;
                end
                ARMED: begin
                    if (RET_INST == HALT_W1)
                        state_d = HALTED;
                    else if (RET_INST == HALT_W0)
                        state_d = ARMED;
                    else
                        state_d = IDLE;
                end
                HALTED:  state_d = HALTED;
                default: state_d = IDLE;
            endcase
`ifdef RETIRE_EBREAK_HALT_EN
            if (RET_INST == EBREAK)
                state_d = HALTED;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            NUM_INST    <= 32'd0;
            OUTPUT_PORT <= 32'd0;
            HALT        <= 1'b0;
        end else if (accept) begin
            if (NUM_INST != 32'hFFFFFFFF)
                NUM_INST <= NUM_INST + 32'd1;
            // Store address outranks branch outcome, which outranks rd data.
            if (RET_IS_ST)
                OUTPUT_PORT <= {20'b0, RET_ST_ADDR};
            else if (RET_IS_BR)
                OUTPUT_PORT <= {31'b0, RET_BR_TAKEN};
            else if (RET_RF_WE)
                OUTPUT_PORT <= RET_RF_WD;
            if (state_d == HALTED)
                HALT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// tb/tb_riscv_retire_monitor.sv - directed self-checking bench for riscv_retire_monitor
module tb_riscv_retire_monitor;

    localparam logic [31:0] W0     = 32'h00c00093;
    localparam logic [31:0] W1     = 32'h00008067;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] ADD    = 32'h002081b3;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RET_VALID = 1'b0;
    logic [31:0] RET_INST = 32'd0;
    logic        RET_RF_WE = 1'b0;
    logic [31:0] RET_RF_WD = 32'd0;
    logic        RET_IS_BR = 1'b0;
    logic        RET_BR_TAKEN = 1'b0;
    logic        RET_IS_ST = 1'b0;
    logic [11:0] RET_ST_ADDR = 12'd0;
    logic [31:0] NUM_INST;
    logic [31:0] OUTPUT_PORT;
    logic        HALT;

    int tests_run = 0;
    int tests_failed = 0;

    riscv_retire_monitor dut (
        .CLK          (CLK),
        .RST          (RST),
        .RET_VALID    (RET_VALID),
        .RET_INST     (RET_INST),
        .RET_RF_WE    (RET_RF_WE),
        .RET_RF_WD    (RET_RF_WD),
        .RET_IS_BR    (RET_IS_BR),
        .RET_BR_TAKEN (RET_BR_TAKEN),
        .RET_IS_ST    (RET_IS_ST),
        .RET_ST_ADDR  (RET_ST_ADDR),
        .NUM_INST     (NUM_INST),
        .OUTPUT_PORT  (OUTPUT_PORT),
        .HALT         (HALT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one retirement between edges, then sample 1 ns after the counting edge.
    task automatic retire(input logic [31:0] inst, input logic we, input logic [31:0] wd,
                          input logic br, input logic tk, input logic st, input logic [11:0] addr);
        @(negedge CLK);
        RET_VALID = 1'b1;
        RET_INST = inst;
        RET_RF_WE = we;
        RET_RF_WD = wd;
        RET_IS_BR = br;
        RET_BR_TAKEN = tk;
        RET_IS_ST = st;
        RET_ST_ADDR = addr;
        @(posedge CLK);
        #1;
        RET_VALID = 1'b0;
        RET_RF_WE = 1'b0;
        RET_IS_BR = 1'b0;
        RET_IS_ST = 1'b0;
    endtask

    task automatic bubble();
        @(negedge CLK);
        RET_VALID = 1'b0;
        RET_INST = 32'hDEADBEEF;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    initial begin
        #12;
        RST = 1'b0;
        check("reset_num", NUM_INST, 32'd0);
        check("reset_out", OUTPUT_PORT, 32'd0);
        check("reset_halt", {31'd0, HALT}, 32'd0);

        retire(NOP, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 12'h000);
        check("b2b1_num", NUM_INST, 32'd1);
        check("b2b1_out", OUTPUT_PORT, 32'd5);
        retire(NOP, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 12'h000);
        check("b2b2_num", NUM_INST, 32'd2);
        check("b2b2_out", OUTPUT_PORT, 32'd0);
        retire(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 12'h0A4);
        check("b2b3_num", NUM_INST, 32'd3);
        check("b2b3_out", OUTPUT_PORT, 32'h0A4);
        retire(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("b2b4_num", NUM_INST, 32'd4);
        check("b2b4_out", OUTPUT_PORT, 32'h0A4);

        // Reach 7 with the FSM left ARMED, then reset asynchronously mid-cycle.
        retire(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(W0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 12'h000);
        check("pre_rst_num", NUM_INST, 32'd7);
        check("pre_rst_halt", {31'd0, HALT}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("async_rst_num", NUM_INST, 32'd0);
        check("async_rst_out", OUTPUT_PORT, 32'd0);
        check("async_rst_halt", {31'd0, HALT}, 32'd0);
        #1;
        RST = 1'b0;
        retire(W1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("post_rst_num", NUM_INST, 32'd1);
        check("post_rst_disarmed", {31'd0, HALT}, 32'd0);

        do_reset();
        retire(NOP, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b1, 12'h010);
        check("prio_st_over_we", OUTPUT_PORT, 32'h010);
        retire(NOP, 1'b1, 32'hFF, 1'b1, 1'b1, 1'b0, 12'h000);
        check("prio_br_over_we", OUTPUT_PORT, 32'd1);

        do_reset();
        retire(W0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 12'h000);
        bubble();
        bubble();
        retire(W1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("halt_bub_halt", {31'd0, HALT}, 32'd1);
        check("halt_bub_num", NUM_INST, 32'd2);
        check("halt_bub_out", OUTPUT_PORT, 32'd12);
        retire(NOP, 1'b1, 32'd99, 1'b0, 1'b0, 1'b0, 12'h000);
        check("halted_num", NUM_INST, 32'd2);
        check("halted_out", OUTPUT_PORT, 32'd12);

        do_reset();
        retire(W0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(ADD, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(W1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("disarm_halt", {31'd0, HALT}, 32'd0);
        check("disarm_num", NUM_INST, 32'd3);

        do_reset();
        retire(W0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(W0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 12'h000);
        check("rearm_halt_pre", {31'd0, HALT}, 32'd0);
        retire(W1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("rearm_halt", {31'd0, HALT}, 32'd1);
        check("rearm_num", NUM_INST, 32'd3);

        do_reset();
        @(negedge CLK);
        force dut.NUM_INST = 32'hFFFFFFFE;
        #1;
        release dut.NUM_INST;
        #1;
        check("sat_preload", NUM_INST, 32'hFFFFFFFE);
        retire(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("sat_top", NUM_INST, 32'hFFFFFFFF);
        retire(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("sat_hold", NUM_INST, 32'hFFFFFFFF);

        do_reset();
        retire(EBREAK, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("ebreak_num", NUM_INST, 32'd1);
`ifdef RETIRE_EBREAK_HALT_EN
        check("ebreak_halt", {31'd0, HALT}, 32'd1);
`else
        check("ebreak_halt", {31'd0, HALT}, 32'd0);
        do_reset();
        retire(W0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(EBREAK, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        retire(W1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        check("ebreak_disarm_halt", {31'd0, HALT}, 32'd0);
        check("ebreak_disarm_num", NUM_INST, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
